// File: rtl/divider_pkg.sv
// ---------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the multicycle divider:
//   state_t        FSM state encoding (IDLE, CALC, DONE)
//   cnt_width()    width of the iteration counter for given M and K
//   DBZ_QUOTIENT   all-ones pattern driven as quotient on a zero divisor;
//                  users take the low M bits
// ---------------------------------------------------------------------------
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest quotient the all-ones constant can cover.
    localparam int MAX_QUOTIENT_W = 64;

    localparam logic [MAX_QUOTIENT_W-1:0] DBZ_QUOTIENT = '1;

    // The counter is loaded with M/K and counts down to 1, so it must
    // represent M/K itself.
    function automatic int cnt_width(input int m, input int k);
        return $clog2(m / k + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
//   rem_in   [N:0]   partial remainder entering the step
//   bit_in           next dividend bit, shifted into the remainder LSB
//   divisor  [N-1:0] divisor
//   rem_out  [N:0]   partial remainder leaving the step
//   q_bit            quotient bit resolved by this step
// ---------------------------------------------------------------------------
module div_step #(
    parameter int N = 14
) (
    input  logic [N:0]   rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N:0] shifted;
    logic [N:0] divisor_ext;

    always_comb begin
        shifted     = {rem_in[N-1:0], bit_in};
        divisor_ext = {1'b0, divisor};
        // A set MSB on the incoming remainder means the shifted value is at
        // least 2^(N+1), which always exceeds the divisor. The subtraction
        // wraps correctly in N+1 bits because the true difference is below
        // the divisor.
        q_bit       = rem_in[N] | (shifted >= divisor_ext);
        rem_out     = q_bit ? (shifted - divisor_ext) : shifted;
    end

endmodule

// File: rtl/multicycle_divider.sv
// ---------------------------------------------------------------------------
// multicycle_divider
// Unsigned M/N divider resolving K quotient bits per clock.
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   in_valid     operands present
//   in_ready     operands accepted (IDLE and not in reset)
//   dividend [M] unsigned dividend
//   divisor  [N] unsigned divisor
//   out_valid    result present (registered)
//   out_ready    consumer takes result
//   quotient [M] unsigned quotient (registered)
//   remainder[N] unsigned remainder (registered)
//   div_by_zero  result came from a zero divisor (registered)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Operands are sampled only on that edge. out_valid and the result
// stay stable until they are taken; in_ready never rises in the same cycle a
// result is taken, so operation is strictly one-at-a-time.
// ---------------------------------------------------------------------------
module multicycle_divider
    import divider_pkg::*;
#(
    parameter int M = 26,
    parameter int N = 14,
    parameter int K = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int ITER = M / K;
    localparam int CW   = cnt_width(M, K);

    if ((M % K) != 0) begin : g_bad_k
        $error("multicycle_divider: M must be divisible by K");
    end

    if (M > MAX_QUOTIENT_W) begin : g_bad_m
        $error("multicycle_divider: M exceeds the all-ones quotient constant");
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [M-1:0]   dvd_sh;     // dividend, consumed from the MSB end
    logic [N-1:0]   dvs;        // divisor held for the whole operation
    logic [N:0]     prem;       // partial remainder between cycles
    logic [M-1:0]   quo_sh;     // quotient bits collected so far

    // FSM decode
    logic accept;
    logic step;
    logic last_step;
    logic result_taken;

    // Step chain
    logic [N:0]     rem_chain [K+1];
    logic [K-1:0]   q_bits;
    logic [M-1:0]   quo_next;
    logic [M-1:0]   dvd_next;

    // ------------------------------------------------------------------
    // K chained restoring steps per CALC cycle
    // ------------------------------------------------------------------
    assign rem_chain[0] = prem;

    for (genvar j = 0; j < K; j++) begin : g_step
        div_step #(
            .N(N)
        ) u_step (
            .rem_in  (rem_chain[j]),
            .bit_in  (dvd_sh[M-1-j]),
            .divisor (dvs),
            .rem_out (rem_chain[j+1]),
            .q_bit   (q_bits[K-1-j])
        );
    end

    // The first step resolves the most significant of the K new bits.
    assign quo_next = (quo_sh << K) | M'(q_bits);
    assign dvd_next = dvd_sh << K;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        accept       = 1'b0;
        step         = 1'b0;
        last_step    = 1'b0;
        result_taken = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = !rst;
                accept   = in_valid && !rst;
                if (accept) begin
                    state_next = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt == CW'(1)) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    result_taken = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, iteration and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            dvd_sh      <= '0;
            dvs         <= '0;
            prem        <= '0;
            quo_sh      <= '0;
        end else begin
            if (accept) begin
                dvd_sh <= dividend;
                dvs    <= divisor;
                prem   <= '0;
                quo_sh <= '0;
                cnt    <= CW'(ITER);
                // A zero divisor skips CALC; the result is known at once.
                if (divisor == '0) begin
                    quotient    <= DBZ_QUOTIENT[M-1:0];
                    remainder   <= dividend[N-1:0];
                    div_by_zero <= 1'b1;
                    out_valid   <= 1'b1;
                end
            end

            if (step) begin
                dvd_sh <= dvd_next;
                prem   <= rem_chain[K];
                quo_sh <= quo_next;
                cnt    <= cnt - CW'(1);
                // The remainder is below the divisor after the last step, so
                // its top bit is always zero.
                if (last_step) begin
                    quotient    <= quo_next;
                    remainder   <= rem_chain[K][N-1:0];
                    div_by_zero <= 1'b0;
                    out_valid   <= 1'b1;
                end
            end

            if (result_taken) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_divider.sv
// ---------------------------------------------------------------------------
// tb_multicycle_divider
// Three divider instances (K = 2, 1, 13) sharing clock and reset. Directed
// cases and randomised operands are compared against an arithmetic model of
// the division rules through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_multicycle_divider;

    localparam int M    = 26;
    localparam int N    = 14;
    localparam int NDUT = 3;
    localparam int RW   = 1 + M + N;

    function automatic int k_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 13;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // DUTs
    // ------------------------------------------------------------------
    logic         in_valid_a    [NDUT];
    logic         in_ready_a    [NDUT];
    logic [M-1:0] dividend_a    [NDUT];
    logic [N-1:0] divisor_a     [NDUT];
    logic         out_valid_a   [NDUT];
    logic         out_ready_a   [NDUT];
    logic [M-1:0] quotient_a    [NDUT];
    logic [N-1:0] remainder_a   [NDUT];
    logic         dbz_a         [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        multicycle_divider #(
            .M(M),
            .N(N),
            .K(k_of(g))
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (in_valid_a[g]),
            .in_ready    (in_ready_a[g]),
            .dividend    (dividend_a[g]),
            .divisor     (divisor_a[g]),
            .out_valid   (out_valid_a[g]),
            .out_ready   (out_ready_a[g]),
            .quotient    (quotient_a[g]),
            .remainder   (remainder_a[g]),
            .div_by_zero (dbz_a[g])
        );
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [RW-1:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on the division rules.
    function automatic logic [RW-1:0] model(input logic [M-1:0] a, input logic [N-1:0] b);
        logic [M-1:0] q;
        logic [N-1:0] r;
        if (b == '0) begin
            q = '1;
            r = a[N-1:0];
            return {1'b1, q, r};
        end
        q = a / M'(b);
        r = N'(a % M'(b));
        return {1'b0, q, r};
    endfunction

    function automatic logic [M-1:0] rand_dividend();
        logic [M-1:0] v;
        case ($urandom_range(0, 4))
            0:       v = M'($urandom_range(0, 100));
            1:       v = '1;
            2:       v = M'($urandom) >> $urandom_range(0, M - 1);
            default: v = M'($urandom);
        endcase
        return v;
    endfunction

    function automatic logic [N-1:0] rand_divisor();
        logic [N-1:0] v;
        case ($urandom_range(0, 9))
            0:       v = '0;
            1:       v = N'(1);
            2:       v = '1;
            3, 4:    v = N'($urandom_range(1, 20));
            default: v = N'($urandom);
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Driver: one full transaction on instance idx, with hold cycles of
    // back-pressure once the result appears. in_valid stays high through
    // CALC/DONE with scrambled operands and drops only after the result
    // handshake edge.
    // ------------------------------------------------------------------
    task automatic run_op(input int idx, input logic [M-1:0] a, input logic [N-1:0] b,
                          input int hold);
        logic [RW-1:0] exp_r;
        int cyc;
        int exp_lat;
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready_a[idx]), 64'd1);
        in_valid_a[idx] = 1'b1;
        dividend_a[idx] = a;
        divisor_a[idx]  = b;
        exp_q.push_back(model(a, b));
        exp_lat = (b == '0) ? 1 : (M / k_of(idx) + 1);
        @(posedge clk);
        #1;
        dividend_a[idx] = M'($urandom);
        divisor_a[idx]  = N'($urandom);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid_a[idx] && cyc < 300);
        check("latency", 64'(cyc), 64'(exp_lat));
        exp_r = exp_q.pop_front();
        check("quotient",    64'(quotient_a[idx]),  64'(exp_r[N +: M]));
        check("remainder",   64'(remainder_a[idx]), 64'(exp_r[N-1:0]));
        check("div_by_zero", 64'(dbz_a[idx]),       64'(exp_r[RW-1]));
        check("in_ready_busy", 64'(in_ready_a[idx]), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 64'(out_valid_a[idx]), 64'd1);
            check("hold_result", 64'({dbz_a[idx], quotient_a[idx], remainder_a[idx]}), 64'(exp_r));
            check("hold_in_ready", 64'(in_ready_a[idx]), 64'd0);
        end
        out_ready_a[idx] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_a[idx]  = 1'b0;
        out_ready_a[idx] = 1'b0;
        @(negedge clk);
        check("in_ready_after", 64'(in_ready_a[idx]), 64'd1);
        check("out_valid_after", 64'(out_valid_a[idx]), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < NDUT; i++) begin
            in_valid_a[i]  = 1'b0;
            dividend_a[i]  = '0;
            divisor_a[i]   = '0;
            out_ready_a[i] = 1'b0;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check("rst_out_valid", 64'(out_valid_a[i]), 64'd0);
            check("rst_in_ready",  64'(in_ready_a[i]),  64'd0);
            check("rst_result", 64'({dbz_a[i], quotient_a[i], remainder_a[i]}), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check("rel_in_ready", 64'(in_ready_a[i]), 64'd1);
        end

        // Directed cases on the default K=2 instance
        run_op(0, M'(100000), N'(7), 0);
        run_op(0, M'(67108863), N'(1), 0);
        run_op(0, M'(10), N'(20), 0);
        run_op(0, M'(5), N'(0), 0);
        run_op(0, M'(12345678), N'(999), 5);   // back-pressure
        run_op(0, M'(777), N'(0), 3);          // back-pressure on zero divisor

        // Reset during CALC aborts the operation
        @(negedge clk);
        in_valid_a[0] = 1'b1;
        dividend_a[0] = M'(100000);
        divisor_a[0]  = N'(7);
        @(posedge clk);
        #1;
        in_valid_a[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out_valid", 64'(out_valid_a[0]), 64'd0);
        check("abort_result", 64'({dbz_a[0], quotient_a[0], remainder_a[0]}), 64'd0);
        check("abort_in_ready", 64'(in_ready_a[0]), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_rel_in_ready", 64'(in_ready_a[0]), 64'd1);
        repeat (15) @(negedge clk);
        check("abort_no_result", 64'(out_valid_a[0]), 64'd0);
        run_op(0, M'(1000), N'(3), 0);

        // Randomised operands on each K
        for (int i = 0; i < NDUT; i++) begin
            int count;
            count = (i == 1) ? 600 : 1500;
            for (int n = 0; n < count; n++) begin
                int hold;
                hold = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3);
                run_op(i, rand_dividend(), rand_divisor(), hold);
            end
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
